// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, ALU op
// codes, instruction opcode/funct fields and datapath mux selects.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_EXEC_LUI  = 4'd4,
        S_ALU_WB    = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WRITE = 4'd9,
        S_BRANCH    = 4'd10,
        S_ILLEGAL   = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/main_decoder.sv
// Combinational instruction decoder: picks the state that follows DECODE and
// flags R-type subtraction.
module main_decoder
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output state_t     next_state,
    output logic       sub_sel
);

    always_comb begin
        next_state = S_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB))
                    next_state = S_EXEC_R;
            end
            OP_ITYPE: begin
                if (funct3 == F3_ADD)
                    next_state = S_EXEC_I;
            end
            OP_LOAD, OP_STORE: begin
                if (funct3 == F3_WORD)
                    next_state = S_MEM_ADDR;
            end
            OP_LUI: next_state = S_EXEC_LUI;
            OP_BRANCH: begin
                if (funct3 == F3_BEQ)
                    next_state = S_BRANCH;
            end
            default: next_state = S_ILLEGAL;
        endcase
    end

    assign sub_sel = (funct7 == F7_SUB);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the RV32I subset add/sub/addi/lw/sw/lui/beq,
// driving ALU controls, datapath strobes and a wait-state memory handshake.
module multicycle_control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode_i,
    input  logic [2:0] Funct3_i,
    input  logic [6:0] Funct7_i,
    input  logic       Zero_i,
    input  logic       Mem_Ready_i,
    output logic       Mem_Req_o,
    output logic       Mem_Write_o,
    output logic       IorD_o,
    output logic       IR_Write_o,
    output logic       PC_Write_o,
    output logic       Reg_Write_o,
    output logic [1:0] ALU_Src_A_o,
    output logic [1:0] ALU_Src_B_o,
    output logic [3:0] ALU_Operation_o,
    output logic [1:0] Result_Src_o,
    output logic       Illegal_o,
    output logic [3:0] State_o
);

    state_t state;
    state_t next_state;
    state_t decode_next;
    logic   sub_sel;
    logic   active;

    main_decoder u_main_decoder (
        .opcode     (Opcode_i),
        .funct3     (Funct3_i),
        .funct7     (Funct7_i),
        .next_state (decode_next),
        .sub_sel    (sub_sel)
    );

    // 'active' keeps every output at zero until the first edge after reset
    // release, and holds the FSM in FETCH until then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_FETCH;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            if (active)
                state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        Mem_Req_o       = 1'b0;
        Mem_Write_o     = 1'b0;
        IorD_o          = 1'b0;
        IR_Write_o      = 1'b0;
        PC_Write_o      = 1'b0;
        Reg_Write_o     = 1'b0;
        ALU_Src_A_o     = SRC_A_PC;
        ALU_Src_B_o     = SRC_B_RS2;
        ALU_Operation_o = ALU_ADD;
        Result_Src_o    = RES_ALUOUT;
        Illegal_o       = 1'b0;
        if (active) begin
            case (state)
                S_FETCH: begin
                    Mem_Req_o    = 1'b1;
                    ALU_Src_A_o  = SRC_A_PC;
                    ALU_Src_B_o  = SRC_B_FOUR;
                    Result_Src_o = RES_ALU;
                    if (Mem_Ready_i) begin
                        IR_Write_o = 1'b1;
                        PC_Write_o = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALU_Src_A_o = SRC_A_OLDPC;
                    ALU_Src_B_o = SRC_B_IMM;
                    next_state  = decode_next;
                end
                S_EXEC_R: begin
                    ALU_Src_A_o     = SRC_A_RS1;
                    ALU_Src_B_o     = SRC_B_RS2;
                    ALU_Operation_o = sub_sel ? ALU_SUB : ALU_ADD;
                    next_state      = S_ALU_WB;
                end
                S_EXEC_I: begin
                    ALU_Src_A_o = SRC_A_RS1;
                    ALU_Src_B_o = SRC_B_IMM;
                    next_state  = S_ALU_WB;
                end
                S_EXEC_LUI: begin
                    ALU_Src_B_o     = SRC_B_IMM;
                    ALU_Operation_o = ALU_LUI;
                    next_state      = S_ALU_WB;
                end
                S_ALU_WB: begin
                    Reg_Write_o  = 1'b1;
                    Result_Src_o = RES_ALUOUT;
                    next_state   = S_FETCH;
                end
                S_MEM_ADDR: begin
                    ALU_Src_A_o = SRC_A_RS1;
                    ALU_Src_B_o = SRC_B_IMM;
                    next_state  = (Opcode_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    Mem_Req_o = 1'b1;
                    IorD_o    = 1'b1;
                    if (Mem_Ready_i)
                        next_state = S_MEM_WB;
                end
                S_MEM_WB: begin
                    Reg_Write_o  = 1'b1;
                    Result_Src_o = RES_MEMDATA;
                    next_state   = S_FETCH;
                end
                S_MEM_WRITE: begin
                    Mem_Req_o   = 1'b1;
                    Mem_Write_o = 1'b1;
                    IorD_o      = 1'b1;
                    if (Mem_Ready_i)
                        next_state = S_FETCH;
                end
                S_BRANCH: begin
                    ALU_Src_A_o     = SRC_A_RS1;
                    ALU_Src_B_o     = SRC_B_RS2;
                    ALU_Operation_o = ALU_SUB;
                    Result_Src_o    = RES_ALUOUT;
                    PC_Write_o      = Zero_i;
                    next_state      = S_FETCH;
                end
                S_ILLEGAL: begin
                    Illegal_o  = 1'b1;
                    next_state = S_ILLEGAL;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

    assign State_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the driver queues hand-computed
// per-cycle output vectors, a monitor pops and compares them each cycle.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] Opcode_i;
    logic [2:0] Funct3_i;
    logic [6:0] Funct7_i;
    logic       Zero_i;
    logic       Mem_Ready_i;
    logic       Mem_Req_o;
    logic       Mem_Write_o;
    logic       IorD_o;
    logic       IR_Write_o;
    logic       PC_Write_o;
    logic       Reg_Write_o;
    logic [1:0] ALU_Src_A_o;
    logic [1:0] ALU_Src_B_o;
    logic [3:0] ALU_Operation_o;
    logic [1:0] Result_Src_o;
    logic       Illegal_o;
    logic [3:0] State_o;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk             (clk),
        .reset           (reset),
        .Opcode_i        (Opcode_i),
        .Funct3_i        (Funct3_i),
        .Funct7_i        (Funct7_i),
        .Zero_i          (Zero_i),
        .Mem_Ready_i     (Mem_Ready_i),
        .Mem_Req_o       (Mem_Req_o),
        .Mem_Write_o     (Mem_Write_o),
        .IorD_o          (IorD_o),
        .IR_Write_o      (IR_Write_o),
        .PC_Write_o      (PC_Write_o),
        .Reg_Write_o     (Reg_Write_o),
        .ALU_Src_A_o     (ALU_Src_A_o),
        .ALU_Src_B_o     (ALU_Src_B_o),
        .ALU_Operation_o (ALU_Operation_o),
        .Result_Src_o    (Result_Src_o),
        .Illegal_o       (Illegal_o),
        .State_o         (State_o)
    );

    typedef struct {
        string       name;
        logic [20:0] vec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] nextOp = 7'b0110011;
    logic [2:0] nextF3 = 3'b000;
    logic [6:0] nextF7 = 7'b0000000;

    logic [20:0] actual;
    assign actual = {State_o, Illegal_o, Result_Src_o, ALU_Operation_o, ALU_Src_B_o,
                     ALU_Src_A_o, Reg_Write_o, PC_Write_o, IR_Write_o, IorD_o,
                     Mem_Write_o, Mem_Req_o};

    logic [20:0] vZero, vFetchR, vFetchW, vDecode, vExecAdd, vExecSub, vExecI, vExecLui;
    logic [20:0] vAluWb, vMemAddr, vMemRead, vMemWb, vMemWrite, vBranch1, vBranch0, vIllegal;

    function automatic logic [20:0] mk(input logic [3:0] st, input logic req, input logic wr,
                                       input logic iord, input logic irw, input logic pcw,
                                       input logic rw, input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] op, input logic [1:0] rs,
                                       input logic ill);
        return {st, ill, rs, op, b, a, rw, pcw, irw, iord, wr, req};
    endfunction

    task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        nextOp = op;
        nextF3 = f3;
        nextF7 = f7;
    endtask

    // Inputs change just after the rising edge; the expected outputs for the
    // cycle that edge starts are queued for the monitor.
    task automatic applyStimulus(input string name, input logic rst, input logic ready,
                                 input logic zero, input logic [20:0] ev);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        Mem_Ready_i = ready;
        Zero_i      = zero;
        Opcode_i    = nextOp;
        Funct3_i    = nextF3;
        Funct7_i    = nextF7;
        e.name = name;
        e.vec  = ev;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [20:0] ev);
        checks++;
        if (actual !== ev) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, ev);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput(e.name, e.vec);
            end
        end
    end

    initial begin
        vZero     = '0;
        vFetchR   = mk(4'd0,  1,0,0,1,1,0, 2'b00,2'b10,4'b0000,2'b10,0);
        vFetchW   = mk(4'd0,  1,0,0,0,0,0, 2'b00,2'b10,4'b0000,2'b10,0);
        vDecode   = mk(4'd1,  0,0,0,0,0,0, 2'b01,2'b01,4'b0000,2'b00,0);
        vExecAdd  = mk(4'd2,  0,0,0,0,0,0, 2'b10,2'b00,4'b0000,2'b00,0);
        vExecSub  = mk(4'd2,  0,0,0,0,0,0, 2'b10,2'b00,4'b0001,2'b00,0);
        vExecI    = mk(4'd3,  0,0,0,0,0,0, 2'b10,2'b01,4'b0000,2'b00,0);
        vExecLui  = mk(4'd4,  0,0,0,0,0,0, 2'b00,2'b01,4'b1000,2'b00,0);
        vAluWb    = mk(4'd5,  0,0,0,0,0,1, 2'b00,2'b00,4'b0000,2'b00,0);
        vMemAddr  = mk(4'd6,  0,0,0,0,0,0, 2'b10,2'b01,4'b0000,2'b00,0);
        vMemRead  = mk(4'd7,  1,0,1,0,0,0, 2'b00,2'b00,4'b0000,2'b00,0);
        vMemWb    = mk(4'd8,  0,0,0,0,0,1, 2'b00,2'b00,4'b0000,2'b01,0);
        vMemWrite = mk(4'd9,  1,1,1,0,0,0, 2'b00,2'b00,4'b0000,2'b00,0);
        vBranch1  = mk(4'd10, 0,0,0,0,1,0, 2'b10,2'b00,4'b0001,2'b00,0);
        vBranch0  = mk(4'd10, 0,0,0,0,0,0, 2'b10,2'b00,4'b0001,2'b00,0);
        vIllegal  = mk(4'd11, 0,0,0,0,0,0, 2'b00,2'b00,4'b0000,2'b00,1);

        reset       = 1'b1;
        Mem_Ready_i = 1'b1;
        Zero_i      = 1'b0;
        Opcode_i    = 7'b0110011;
        Funct3_i    = 3'b000;
        Funct7_i    = 7'b0000000;
        #1 reset = 1'b0;

        for (int i = 0; i < 3; i++)
            applyStimulus("reset_hold", 0, 1, 0, vZero);
        applyStimulus("reset_release", 1, 1, 0, vZero);

        setInstr(7'b0110011, 3'b000, 7'b0000000);
        applyStimulus("add_fetch",  1, 1, 0, vFetchR);
        applyStimulus("add_decode", 1, 1, 0, vDecode);
        applyStimulus("add_exec",   1, 1, 0, vExecAdd);
        applyStimulus("add_wb",     1, 1, 0, vAluWb);

        setInstr(7'b0110011, 3'b000, 7'b0100000);
        applyStimulus("sub_fetch",  1, 1, 0, vFetchR);
        applyStimulus("sub_decode", 1, 1, 0, vDecode);
        applyStimulus("sub_exec",   1, 1, 0, vExecSub);
        applyStimulus("sub_wb",     1, 1, 0, vAluWb);

        setInstr(7'b0010011, 3'b000, 7'b0000000);
        applyStimulus("addi_fetch",  1, 1, 0, vFetchR);
        applyStimulus("addi_decode", 1, 1, 0, vDecode);
        applyStimulus("addi_exec",   1, 1, 0, vExecI);
        applyStimulus("addi_wb",     1, 1, 0, vAluWb);

        setInstr(7'b0000011, 3'b010, 7'b0000000);
        applyStimulus("lw_fetch_wait1", 1, 0, 0, vFetchW);
        applyStimulus("lw_fetch_wait2", 1, 0, 0, vFetchW);
        applyStimulus("lw_fetch_done",  1, 1, 0, vFetchR);
        applyStimulus("lw_decode",      1, 1, 0, vDecode);
        applyStimulus("lw_addr",        1, 1, 0, vMemAddr);
        applyStimulus("lw_read_wait1",  1, 0, 0, vMemRead);
        applyStimulus("lw_read_wait2",  1, 0, 0, vMemRead);
        applyStimulus("lw_read_done",   1, 1, 0, vMemRead);
        applyStimulus("lw_wb_cycle9",   1, 1, 0, vMemWb);

        setInstr(7'b0100011, 3'b010, 7'b0000000);
        applyStimulus("sw_fetch",  1, 1, 0, vFetchR);
        applyStimulus("sw_decode", 1, 1, 0, vDecode);
        applyStimulus("sw_addr",   1, 1, 0, vMemAddr);
        applyStimulus("sw_write",  1, 1, 0, vMemWrite);

        setInstr(7'b1100011, 3'b000, 7'b0000000);
        applyStimulus("beq_t_fetch",  1, 1, 0, vFetchR);
        applyStimulus("beq_t_decode", 1, 1, 0, vDecode);
        applyStimulus("beq_t_branch", 1, 1, 1, vBranch1);
        applyStimulus("beq_n_fetch",  1, 1, 0, vFetchR);
        applyStimulus("beq_n_decode", 1, 1, 0, vDecode);
        applyStimulus("beq_n_branch", 1, 1, 0, vBranch0);

        setInstr(7'b0110111, 3'b000, 7'b0000000);
        applyStimulus("lui_fetch",  1, 1, 0, vFetchR);
        applyStimulus("lui_decode", 1, 1, 0, vDecode);
        applyStimulus("lui_exec",   1, 1, 0, vExecLui);
        applyStimulus("lui_wb",     1, 1, 0, vAluWb);

        setInstr(7'b0100011, 3'b010, 7'b0000000);
        applyStimulus("swr_fetch",     1, 1, 0, vFetchR);
        applyStimulus("swr_decode",    1, 1, 0, vDecode);
        applyStimulus("swr_addr",      1, 1, 0, vMemAddr);
        applyStimulus("swr_write_wait",1, 0, 0, vMemWrite);
        applyStimulus("swr_reset_drop",0, 0, 0, vZero);
        applyStimulus("swr_reset_hold",0, 0, 0, vZero);
        applyStimulus("swr_release",   1, 0, 0, vZero);

        setInstr(7'b1111111, 3'b000, 7'b0000000);
        applyStimulus("ill_fetch",  1, 1, 0, vFetchR);
        applyStimulus("ill_decode", 1, 1, 0, vDecode);
        for (int i = 0; i < 20; i++)
            applyStimulus("ill_hold", 1, 1, 0, vIllegal);
        applyStimulus("ill_reset",   0, 1, 0, vZero);
        applyStimulus("ill_release", 1, 0, 0, vZero);
        applyStimulus("ill_refetch", 1, 0, 0, vFetchW);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
